// File: rtl/ccd_word_packer.sv
// ccd_word_packer: packs cropped 8-bit pixels, 16 per 256-bit word, into WORDS bmem writes per armed frame.
// Optional macro PACK_CHECKSUM_EN adds oSUM, the sum of every pixel that went into a written word.
module ccd_word_packer #(
    parameter int PIX_W  = 8,
    parameter int LANE_W = 16,
    parameter int LANES  = 16,
    parameter int WORDS  = 49,
    parameter int ADDR_W = 7
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iENABLE,
    input  logic                      iSTART,
    input  logic                      iFVAL,
    input  logic                      iDVAL,
    input  logic [PIX_W-1:0]          iDATA,
    output logic                      oWREN,
    output logic [ADDR_W-1:0]         oADDR,
    output logic [LANES*LANE_W-1:0]   oDATA,
    output logic                      oDONE,
    output logic                      oBUSY,
`ifdef PACK_CHECKSUM_EN
    output logic [PIX_W+10-1:0]       oSUM,
`endif
    output logic [1:0]                oSTATE
);
    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    state_t                    state;
    logic [LW-1:0]             lane;
    logic [ADDR_W:0]           wcnt;
    logic                      fval_d;
    logic [LANES*LANE_W-1:0]   pack;
    logic [LANES*LANE_W-1:0]   pack_nx;
    logic                      full;
    logic                      lane_end;
    logic                      arm;
    logic                      retry;
    logic                      take;

    // wcnt reaching WORDS marks the final write cycle; pixels are refused from then on
    assign full     = wcnt == (ADDR_W+1)'(WORDS);
    assign lane_end = lane == LW'(LANES-1);
    assign arm      = iENABLE && iSTART && (state == IDLE || state == DONE);
    assign retry    = state == CAPTURE && iENABLE && !full && !iFVAL;
    assign take     = state == CAPTURE && iENABLE && !full && iFVAL && iDVAL;
    assign oSTATE   = state;

    always_comb begin
        pack_nx = pack;
        pack_nx[lane*LANE_W +: LANE_W] = LANE_W'(iDATA);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state  <= IDLE;
            oBUSY  <= 1'b0;
            oWREN  <= 1'b0;
            oADDR  <= '0;
            oDATA  <= '0;
            oDONE  <= 1'b0;
            lane   <= '0;
            wcnt   <= '0;
            fval_d <= 1'b0;
            pack   <= '0;
        end else begin
            fval_d <= iFVAL;
            oWREN  <= 1'b0;
            if (arm) begin
                state <= WAIT_SOF;
                oBUSY <= 1'b1;
                oDONE <= 1'b0;
                lane  <= '0;
                wcnt  <= '0;
            end else begin
                case (state)
                    WAIT_SOF: begin
                        if (!iENABLE) begin
                            state <= IDLE;
                            oBUSY <= 1'b0;
                        end else if (iFVAL && !fval_d) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (!iENABLE) begin
                            state <= IDLE;
                            oBUSY <= 1'b0;
                        end else if (full) begin
                            state <= DONE;
                            oBUSY <= 1'b0;
                            oDONE <= 1'b1;
                        end else if (retry) begin
                            state <= WAIT_SOF;
                            lane  <= '0;
                            wcnt  <= '0;
                        end else if (take) begin
                            pack <= pack_nx;
                            lane <= lane_end ? '0 : lane + 1'b1;
                            if (lane_end) begin
                                oWREN <= 1'b1;
                                oDATA <= pack_nx;
                                oADDR <= wcnt[ADDR_W-1:0];
                                wcnt  <= wcnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (!iENABLE) state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PACK_CHECKSUM_EN
    // part holds the current word's pixels so a discarded partial word never reaches oSUM
    logic [PIX_W+LW-1:0] part;

    always_ff @(posedge iCLK) begin
        if (iRST || arm || retry) begin
            oSUM <= '0;
            part <= '0;
        end else if (take && lane_end) begin
            oSUM <= oSUM + (PIX_W+10)'(part) + (PIX_W+10)'(iDATA);
            part <= '0;
        end else if (take) begin
            part <= part + (PIX_W+LW)'(iDATA);
        end
    end
`endif
endmodule

// File: tb/tb_ccd_word_packer.sv
// tb_ccd_word_packer: directed stimulus with a write scoreboard for ccd_word_packer.
`timescale 1ns/1ps
module tb_ccd_word_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         start = 1'b0;
    logic         fval = 1'b0;
    logic         dval = 1'b0;
    logic [7:0]   data = 8'h00;
    logic         wren;
    logic [6:0]   addr;
    logic [255:0] wdata;
    logic         done;
    logic         busy;
    logic [1:0]   state;
`ifdef PACK_CHECKSUM_EN
    logic [17:0]  sum;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0]   a;
        logic [255:0] d;
    } wr_t;
    wr_t q[$];

    ccd_word_packer dut (
        .iCLK(clk),
        .iRST(rst),
        .iENABLE(en),
        .iSTART(start),
        .iFVAL(fval),
        .iDVAL(dval),
        .iDATA(data),
        .oWREN(wren),
        .oADDR(addr),
        .oDATA(wdata),
        .oDONE(done),
        .oBUSY(busy),
`ifdef PACK_CHECKSUM_EN
        .oSUM(sum),
`endif
        .oSTATE(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // monitor: every write must match the oldest expected write
    always @(negedge clk) begin
        if (wren) begin
            wr_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%h, none required", addr, wdata);
            end else begin
                e = q.pop_front();
                if (e.a !== addr || e.d !== wdata) begin
                    errors++;
                    $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h", addr, wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", n, act, exp);
        end
    endtask

    function automatic logic [255:0] ramp(input int b);
        logic [255:0] r = '0;
        for (int k = 0; k < 16; k++) r[16*k +: 16] = 16'((b + k) % 256);
        return r;
    endfunction

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // frame start (FVAL rise with no pixel) followed by n back-to-back pixels
    task automatic frame(input int n, input int base, input bit ff);
        fval = 1'b1;
        dval = 1'b0;
        tick();
        chk("capture_entry", state, 2);
        for (int i = 0; i < n; i++) begin
            dval = 1'b1;
            data = ff ? 8'hFF : 8'((base + i) % 256);
            if (i % 16 == 15 && i / 16 < 49)
                q.push_back({7'(i / 16), ff ? {16{16'h00FF}} : ramp(base + i - 15)});
            tick();
            chk("wren_cadence", wren, (i % 16 == 15 && i < 784));
            if (i == 783) chk("done_not_yet", done, 0);
            if (i == 784) chk("done_after_last", done, 1);
        end
        dval = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_wren", wren, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state", state, 0);

        // armed mid-frame: that frame is skipped
        en = 1'b1;
        fval = 1'b1;
        dval = 1'b1;
        data = 8'h55;
        arm();
        chk("armed_state", state, 1);
        chk("armed_busy", busy, 1);
        repeat (10) tick();
        chk("skip_frame", state, 1);
        fval = 1'b0;
        dval = 1'b0;
        repeat (2) tick();
        frame(790, 0, 0);
        chk("full_state", state, 3);
        chk("full_busy", busy, 0);
        chk("full_drained", q.size(), 0);
        fval = 1'b0;
        tick();

        // enable drop in DONE keeps the flag; a new arm clears it
        en = 1'b0;
        tick();
        chk("en_drop_state", state, 0);
        chk("en_drop_done", done, 1);
        en = 1'b1;
        arm();
        chk("rearm_state", state, 1);
        chk("rearm_done", done, 0);

        // short frame: 6 words written, 4 leftover pixels dropped, then retry
        frame(100, 0, 0);
        fval = 1'b0;
        tick();
        chk("short_state", state, 1);
        chk("short_busy", busy, 1);
        chk("short_writes", q.size(), 0);
        frame(785, 7, 0);
        chk("retry_state", state, 3);
        chk("retry_done", done, 1);
        fval = 1'b0;
        tick();

        // gapped pixels, and DVAL without FVAL before the frame
        arm();
        dval = 1'b1;
        data = 8'hAA;
        repeat (3) tick();
        fval = 1'b1;
        dval = 1'b0;
        tick();
        q.push_back({7'd0, 256'h001F001E001D001C001B001A0019001800170016001500140013001200110010});
        for (int j = 0; j < 16; j++) begin
            dval = 1'b1;
            data = 8'(8'h10 + j);
            tick();
            if (j % 3 == 0) begin
                dval = 1'b0;
                data = 8'hEE;
                tick();
            end
        end
        dval = 1'b0;
        tick();
        chk("gap_writes", q.size(), 0);
        dval = 1'b1;
        data = 8'h77;
        repeat (3) tick();
        dval = 1'b0;
        fval = 1'b0;
        tick();
        chk("gap_short_state", state, 1);

        // reset after 20 words discards the rest
        frame(325, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_data", wdata, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_state", state, 0);
        fval = 1'b0;
        tick();
        fval = 1'b1;
        dval = 1'b1;
        repeat (10) tick();
        dval = 1'b0;
        chk("no_rearm_state", state, 0);
        fval = 1'b0;
        tick();

`ifdef PACK_CHECKSUM_EN
        arm();
        frame(784, 0, 1);
        tick();
        chk("sum_done", done, 1);
        chk("sum_value", sum, 199920);
        fval = 1'b0;
        tick();
`endif

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ccd_word_packer.md
Name: ccd_word_packer

Overview:
- Camera-side stage that turns the cropped 8-bit grayscale pixel stream into 256-bit data-memory words.
- Packs 16 pixels per word, one 16-bit lane each, and writes a fixed number of words per armed frame through the 256-bit bmem write port.
- Sits between the crop stage and the dual-port bmem. Raises a done flag for the CPU/display side once a full image is stored.

Parameters:
- PIX_W, 8, input pixel width
- LANE_W, 16, lane width per pixel in the output word; pixel is zero-extended to fill it
- LANES, 16, pixels per output word (LANES*LANE_W = 256)
- WORDS, 49, words per frame (28x28 image = 784 pixels)
- ADDR_W, 7, write address width

Ports:
- iCLK  in  1  pixel clock
- iRST  in  1  synchronous reset, active-high
- iENABLE  in  1  CPU permission to capture; 0 holds the block in IDLE
- iSTART  in  1  arm request, level-sampled each cycle
- iFVAL  in  1  frame valid from the sensor front end
- iDVAL  in  1  pixel valid from the crop stage
- iDATA  in  PIX_W  cropped pixel
- oWREN  out  1  bmem write enable, single-cycle pulse
- oADDR  out  ADDR_W  bmem word address
- oDATA  out  LANES*LANE_W  packed word
- oDONE  out  1  image complete (sticky)
- oBUSY  out  1  high in WAIT_SOF or CAPTURE
- oSTATE  out  2  IDLE=0, WAIT_SOF=1, CAPTURE=2, DONE=3

Behaviour:
- Reset (iRST=1 at a rising iCLK edge) forces:
  - state IDLE
  - oWREN=0, oADDR=0, oDATA=0, oDONE=0, oBUSY=0
  - lane counter=0, word counter=0
  - Reset mid-capture discards everything; no write is issued.
- IDLE: if iENABLE && iSTART, go to WAIT_SOF. Counters are cleared on entry to WAIT_SOF.
- WAIT_SOF:
  - Track the previous value of iFVAL.
  - A rising edge of iFVAL (prev=0, now=1) goes to CAPTURE.
  - A frame already in progress when armed is skipped; capture starts on the next frame.
- CAPTURE:
  - A pixel is accepted when iDVAL && iFVAL. If iDVAL=1 while iFVAL=0, the pixel is ignored.
  - Accepted pixel k of a word (k = lane counter, 0..15) is written to lane bits [16k+15:16k] as {8'h00, iDATA}. Lane 0 is the first pixel, at the LSB.
  - On acceptance of lane 15:
    - the next cycle drives oWREN=1 for exactly 1 cycle, with oDATA = the completed word and oADDR = the word counter;
    - the word counter then increments and the lane counter wraps to 0.
  - Write latency: 1 cycle after the 16th pixel.
  - Back-to-back pixels continue packing the next word during the write cycle; there are no stalls.
  - oDATA holds its last written value between writes.
  - After write WORDS-1 (oADDR=48) goes to DONE. Remaining pixels in the frame are ignored.
  - iFVAL falling before WORDS words are written means a short frame:
    - the partial word is discarded and no write is issued;
    - the counters are cleared and the state returns to WAIT_SOF to retry on the next frame;
    - words already written are overwritten by the retry.
  - iSTART during WAIT_SOF or CAPTURE is ignored.
- DONE:
  - oDONE=1 is held.
  - iSTART && iENABLE clears oDONE the same edge and goes to WAIT_SOF.
  - iENABLE=0 goes to IDLE with oDONE kept at 1, cleared only by a new arm or reset.
- iENABLE dropping in WAIT_SOF or CAPTURE: abort to IDLE with no further writes.
- oBUSY = (state==WAIT_SOF || state==CAPTURE), registered together with the state.
- The address never exceeds WORDS-1, so there is no wrap within a frame.

Optional Feature:
- Macro PACK_CHECKSUM_EN.
- When defined:
  - extra output oSUM [PIX_W+10-1:0] (18 bits) holds the sum of all pixels packed into written words;
  - cleared on entry to WAIT_SOF, including a retry;
  - valid and stable while oDONE=1;
  - pixels discarded in a partial word or after DONE are not counted.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, iENABLE=1, pulse iSTART with iFVAL already high, then a full frame of 784 pixels 0..783 mod 256. Required response:
  - no writes until the second iFVAL rise;
  - 49 writes to addresses 0..48;
  - word 0 = lanes 0x0000..0x000F;
  - oDONE=1 one cycle after the last write.
- Continuous iDVAL: oWREN is high exactly 1 cycle after every 16th pixel, and consecutive words lose no pixel.
- Short frame: iFVAL falls after 100 pixels. Required response:
  - 6 writes, no write for the 4 leftover pixels;
  - state returns to 1;
  - the next full frame rewrites from address 0 and reaches DONE.
- Gapped iDVAL plus iDVAL=1 with iFVAL=0: the ignored pixels do not appear, and lane order is preserved.
- Assert iRST after 20 words: all outputs return to 0, state=0, and there are no writes until re-armed.
- With PACK_CHECKSUM_EN and all pixels 0xFF over a full frame: oSUM = 784*255 = 199920 at DONE.
